// File: rtl/n16_fft_pkg.sv
// n16_fft_pkg: shared constants and helpers for the 16-point radix-4 FFT and its output reorder stage
package n16_fft_pkg;
  localparam int N_POINT = 16;
  localparam int LOG4_N = 2;
  typedef enum logic {S_IDLE, S_READ} rd_state_t;
  // Output width of the FFT core: input width + twiddle width + radix-4 growth
  function automatic int out_width(input int dw, input int ww);
    return dw + ww + 2;
  endfunction
  // Base-4 digit reversal of a 2-digit index p = 4a+b -> 4b+a
  function automatic logic [3:0] digit_rev4(input logic [3:0] p);
    return {p[1:0], p[3:2]};
  endfunction
endpackage

// File: rtl/n16_reorder_bank.sv
// n16_reorder_bank: simple dual-port memory, synchronous write and registered synchronous read
module n16_reorder_bank #(
  parameter int W  = 36,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [2**AW];
  // Write port
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  // Registered read port; cleared on reset so the block outputs come up as zero
  always_ff @(posedge clk)
    if (i_rst) o_rdata <= '0;
    else if (i_re) o_rdata <= r_mem[i_raddr];
endmodule

// File: rtl/n16_fft_out_reorder.sv
// n16_fft_out_reorder: restores natural bin order of the 16-point FFT result stream using ping-pong banks.
// Optional macro N16_REORDER_INDEX_EN adds xk_index_o, the bin index aligned with data_out_valid_o.
module n16_fft_out_reorder
  import n16_fft_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int Wn_WIDTH   = 8,
  parameter int N_POINT    = 16,
  localparam int OUT_WIDTH = out_width(DATA_WIDTH, Wn_WIDTH)
) (
  input  logic                        sys_clk_i,
  input  logic                        rst_i,
  input  logic                        data_in_valid_i,
  input  logic signed [OUT_WIDTH-1:0] xk_real_i,
  input  logic signed [OUT_WIDTH-1:0] xk_imag_i,
  output logic                        data_out_valid_o,
  output logic signed [OUT_WIDTH-1:0] xk_real_o,
  output logic signed [OUT_WIDTH-1:0] xk_imag_o,
  output logic                        sof_o
`ifdef N16_REORDER_INDEX_EN
  ,
  output logic [3:0]                  xk_index_o
`endif
);
  if (N_POINT != n16_fft_pkg::N_POINT) begin : g_bad_n
    $error("n16_fft_out_reorder supports N_POINT=16 only");
  end
  localparam int AW = 2 * LOG4_N;
  logic [AW-1:0]          r_wr_cnt;
  logic                   r_wr_bank;
  logic [1:0]             r_full;
  logic                   r_rd_bank;
  logic [AW-1:0]          r_rd_addr;
  rd_state_t              r_state;
  logic                   r_valid;
  logic                   r_sof;
  logic                   w_rd_en;
  logic                   w_rd_last;
  logic                   w_wr_last;
  logic [1:0]             w_set;
  logic [1:0]             w_clr;
  logic [2*OUT_WIDTH-1:0] w_rdata;
  assign w_rd_en   = r_state == S_READ;
  assign w_rd_last = w_rd_en && r_rd_addr == 4'd15;
  assign w_wr_last = data_in_valid_i && r_wr_cnt == 4'd15;
  assign w_set     = w_wr_last ? 2'b01 << r_wr_bank : 2'b00;
  assign w_clr     = w_rd_last ? 2'b01 << r_rd_bank : 2'b00;
  // Writer: counts accepted samples, scatters them to digit-reversed addresses, marks a bank full per frame
  always_ff @(posedge sys_clk_i)
    if (rst_i) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
      r_full    <= '0;
    end else begin
      if (data_in_valid_i) r_wr_cnt <= r_wr_cnt + 4'd1;
      if (w_wr_last) r_wr_bank <= ~r_wr_bank;
      r_full <= (r_full & ~w_clr) | w_set;
    end
  // Reader: sweeps addresses 0..15 of the older bank, chaining straight into the other bank when it is ready
  always_ff @(posedge sys_clk_i)
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_rd_bank <= 1'b0;
      r_rd_addr <= '0;
      r_valid   <= 1'b0;
      r_sof     <= 1'b0;
`ifdef N16_REORDER_INDEX_EN
      xk_index_o <= '0;
`endif
    end else begin
      r_valid <= w_rd_en;
      r_sof   <= w_rd_en && r_rd_addr == '0;
`ifdef N16_REORDER_INDEX_EN
      xk_index_o <= w_rd_en ? r_rd_addr : '0;
`endif
      if (r_state == S_IDLE) begin
        r_rd_addr <= '0;
        if (|r_full) r_state <= S_READ;
      end else begin
        r_rd_addr <= r_rd_addr + 4'd1;
        if (w_rd_last) begin
          r_rd_bank <= ~r_rd_bank;
          r_state   <= r_full[~r_rd_bank] ? S_READ : S_IDLE;
        end
      end
    end
  n16_reorder_bank #(.W(2 * OUT_WIDTH), .AW(AW + 1)) u_bank (
    .clk     (sys_clk_i),
    .i_rst   (rst_i),
    .i_we    (data_in_valid_i),
    .i_waddr ({r_wr_bank, digit_rev4(r_wr_cnt)}),
    .i_wdata ({xk_real_i, xk_imag_i}),
    .i_re    (w_rd_en),
    .i_raddr ({r_rd_bank, r_rd_addr}),
    .o_rdata (w_rdata)
  );
  assign xk_real_o        = w_rdata[2*OUT_WIDTH-1 -: OUT_WIDTH];
  assign xk_imag_o        = w_rdata[OUT_WIDTH-1:0];
  assign data_out_valid_o = r_valid;
  assign sof_o            = r_sof;
`ifndef SYNTHESIS
  // The writer must never land on a bank whose frame has not been fully read out
  a_no_overwrite: assert property (@(posedge sys_clk_i) disable iff (rst_i)
    !(data_in_valid_i && r_full[r_wr_bank] && !w_clr[r_wr_bank]));
`endif
endmodule

// File: tb/tb_n16_fft_out_reorder.sv
// tb_n16_fft_out_reorder: self-checking bench for n16_fft_out_reorder (frame-level scoreboard plus directed tables)
module tb_n16_fft_out_reorder;
  localparam int OW = 18;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vin = 1'b0;
  logic signed [OW-1:0] rin = '0;
  logic signed [OW-1:0] iin = '0;
  logic vout;
  logic sof;
  logic signed [OW-1:0] rout;
  logic signed [OW-1:0] iout;
`ifdef N16_REORDER_INDEX_EN
  logic [3:0] idx;
`endif
  always #5 clk = ~clk;
  n16_fft_out_reorder dut (
    .sys_clk_i        (clk),
    .rst_i            (rst),
    .data_in_valid_i  (vin),
    .xk_real_i        (rin),
    .xk_imag_i        (iin),
    .data_out_valid_o (vout),
    .xk_real_o        (rout),
    .xk_imag_o        (iout),
    .sof_o            (sof)
`ifdef N16_REORDER_INDEX_EN
    ,
    .xk_index_o       (idx)
`endif
  );
  int total = 0;
  int bad = 0;
  task automatic chk(input string n, input longint a, input longint e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", n, a, e);
    end
  endtask
  // Scoreboard: frames of 16 accepted samples; bin k of a frame is input position 4*(k%4)+k/4.
  // A frame starts output 2 edges after its last sample, but never before the previous frame's 16 bins are out.
  typedef struct {longint re; longint im; int k; int cyc;} exp_t;
  exp_t expq[$];
  longint fr_re[16];
  longint fr_im[16];
  longint obs_re[$];
  longint obs_im[$];
  int obs_cyc[$];
  int fcnt = 0;
  int cyc = 0;
  int prev_start = -1000;
  initial forever begin
    exp_t e;
    int st;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      fcnt = 0;
      expq.delete();
      prev_start = -1000;
    end else if (vin) begin
      fr_re[fcnt] = rin;
      fr_im[fcnt] = iin;
      fcnt++;
      if (fcnt == 16) begin
        st = (cyc + 2 > prev_start + 16) ? cyc + 2 : prev_start + 16;
        for (int k = 0; k < 16; k++) begin
          e.re = fr_re[4 * (k % 4) + k / 4];
          e.im = fr_im[4 * (k % 4) + k / 4];
          e.k = k;
          e.cyc = st + k;
          expq.push_back(e);
        end
        prev_start = st;
        fcnt = 0;
      end
    end
    if (vout) begin
      obs_re.push_back(rout);
      obs_im.push_back(iout);
      obs_cyc.push_back(cyc);
    end
    if (rst) begin
      chk("rst_valid", vout, 0);
      chk("rst_sof", sof, 0);
      chk("rst_real", rout, 0);
      chk("rst_imag", iout, 0);
`ifdef N16_REORDER_INDEX_EN
      chk("rst_idx", idx, 0);
`endif
    end else if (expq.size() > 0 && expq[0].cyc == cyc) begin
      e = expq.pop_front();
      chk("sb_valid", vout, 1);
      chk("sb_real", rout, e.re);
      chk("sb_imag", iout, e.im);
      chk("sb_sof", sof, e.k == 0);
`ifdef N16_REORDER_INDEX_EN
      chk("sb_idx", idx, e.k);
`endif
    end else begin
      chk("sb_idle_valid", vout, 0);
      chk("sb_idle_sof", sof, 0);
`ifdef N16_REORDER_INDEX_EN
      chk("sb_idle_idx", idx, 0);
`endif
    end
  end
  typedef struct {longint in_re; longint in_im; longint exp_re; longint exp_im;} vec_t;
  vec_t tv[16];
  int exp_nat[16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
  task automatic send(input longint r, input longint i);
    @(negedge clk);
    vin = 1'b1;
    rin = OW'(r);
    iin = OW'(i);
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      vin = 1'b0;
    end
  endtask
  // Drives the table frame (optionally gapped) and checks latency and the 16 natural-order bins
  task automatic table_frame(input string tag, input bit gap);
    for (int p = 0; p < 16; p++) begin
      send(tv[p].in_re, tv[p].in_im);
      if (gap || p == 15) idle(1);
    end
    @(negedge clk);
    chk({tag, "_early"}, vout, 0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk({tag, "_valid"}, vout, 1);
      chk({tag, "_sof"}, sof, k == 0);
      chk({tag, "_real"}, rout, tv[k].exp_re);
      chk({tag, "_imag"}, iout, tv[k].exp_im);
    end
    @(negedge clk);
    chk({tag, "_end"}, vout, 0);
  endtask
  initial begin
    logic [OW-1:0] t;
    int n;
    for (int k = 0; k < 16; k++) begin
      tv[k].in_re = k;
      tv[k].in_im = -k;
      tv[k].exp_re = exp_nat[k];
      tv[k].exp_im = -exp_nat[k];
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    table_frame("single", 1'b0);
    table_frame("gapped", 1'b1);
    obs_re.delete(); obs_im.delete(); obs_cyc.delete();
    for (int i = 0; i < 48; i++) send(2 * i + 1, -(2 * i + 1));
    idle(60);
    chk("b2b_count", obs_re.size(), 48);
    if (obs_re.size() == 48) begin
      chk("b2b_f2_bin0", obs_re[16], 33);
      chk("b2b_f2_bin1", obs_re[17], 41);
      chk("b2b_contig", obs_cyc[47] - obs_cyc[0], 47);
    end
    for (int i = 0; i < 7; i++) send(100 + i, 0);
    @(negedge clk);
    vin = 1'b0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    obs_re.delete(); obs_im.delete(); obs_cyc.delete();
    for (int p = 0; p < 16; p++) send(p, 0);
    idle(30);
    chk("rstmid_count", obs_re.size(), 16);
    if (obs_re.size() == 16) begin
      chk("rstmid_bin1", obs_re[1], 4);
      chk("rstmid_bin15", obs_re[15], 15);
    end
    obs_re.delete(); obs_im.delete(); obs_cyc.delete();
    for (int p = 0; p < 16; p++)
      send(p == 0 ? -131072 : p == 5 ? 131071 : p, p == 0 ? 131071 : p == 5 ? -131072 : 0);
    idle(30);
    chk("ext_count", obs_re.size(), 16);
    if (obs_re.size() == 16) begin
      chk("ext_bin0_re", obs_re[0], -131072);
      chk("ext_bin0_im", obs_im[0], 131071);
      chk("ext_bin5_re", obs_re[5], 131071);
      chk("ext_bin5_im", obs_im[5], -131072);
    end
    for (int f = 0; f < 8; f++)
      for (int p = 0; p < 16; p++) begin
        t = OW'($urandom);
        send(longint'($signed(t)), longint'($signed(OW'($urandom))));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
    idle(1);
    n = 0;
    while (expq.size() > 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain", expq.size(), 0);
    idle(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
